// File: rtl/uart_rx_if.sv
// Serial receive link: the raw line into the receiver and the byte/strobe
// results coming back out of it.
interface uart_rx_if;
    logic       rx;
    logic [7:0] rx_data;
    logic       donerx;
    logic       frame_err;
    logic       busy;

    // Driver of the serial line, consumer of the received bytes
    modport master (
        output rx,
        input  rx_data,
        input  donerx,
        input  frame_err,
        input  busy
    );

    // The receiver itself
    modport slave (
        input  rx,
        output rx_data,
        output donerx,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, single clock domain.
// The asynchronous line is double-flopped, the start bit is validated at its
// middle, and every following bit is sampled one bit period later, i.e. at
// its middle. Good bytes appear on rx_data with a one-cycle donerx strobe; a
// low stop bit yields a one-cycle frame_err and the receiver waits for the
// line to return high before hunting for the next start bit.
module uart_rx #(
    parameter int clk_freq  = 1000000,
    parameter int baud_rate = 9600
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave bus
);
    // Clocks per bit and per half bit; at least 4 clocks per bit is assumed.
    localparam int C  = clk_freq / baud_rate;
    localparam int H  = C / 2;
    localparam int CW = (C > 1) ? $clog2(C) : 1;

    localparam logic [CW-1:0] C_LAST  = CW'(C - 1);
    localparam logic [CW-1:0] H_LAST  = CW'(H - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        WAIT  = 3'd4
    } state_t;

    logic          rx_meta;
    logic          rx_s;
    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic [2:0]    idx_r;
    logic [7:0]    sh_r;
    logic [7:0]    rx_data_r;
    logic          donerx_r;
    logic          frame_err_r;
    logic          busy_r;

    // Two-flop synchronizer; resets to the idle (high) line level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rx_s    <= rx_meta;
        end
    end

    // Frame FSM with bit timing, shift register and registered strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            idx_r       <= 3'd0;
            sh_r        <= 8'h00;
            rx_data_r   <= 8'h00;
            donerx_r    <= 1'b0;
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            donerx_r    <= 1'b0;
            frame_err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    cnt_r <= '0;
                    if (!rx_s) begin
                        state_r <= START;
                        busy_r  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt_r == H_LAST) begin
                        cnt_r <= '0;
                        idx_r <= 3'd0;
                        if (!rx_s) begin
                            state_r <= DATA;
                        end else begin
                            // Line went back high before mid start bit: glitch
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                DATA: begin
                    if (cnt_r == C_LAST) begin
                        cnt_r <= '0;
                        sh_r  <= {rx_s, sh_r[7:1]};
                        if (idx_r == 3'd7) begin
                            state_r <= STOP;
                        end else begin
                            idx_r <= idx_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                STOP: begin
                    if (cnt_r == C_LAST) begin
                        cnt_r <= '0;
                        if (rx_s) begin
                            rx_data_r <= sh_r;
                            donerx_r  <= 1'b1;
                            state_r   <= IDLE;
                            busy_r    <= 1'b0;
                        end else begin
                            // Leave rx_data alone; wait out a break/stuck-low line
                            frame_err_r <= 1'b1;
                            state_r     <= WAIT;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                WAIT: begin
                    cnt_r <= '0;
                    if (rx_s) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_data   = rx_data_r;
    assign bus.donerx    = donerx_r;
    assign bus.frame_err = frame_err_r;
    assign bus.busy      = busy_r;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames with a scoreboard of expected
// receive events (kind, byte, cycle) checked every cycle, plus literal
// expectations after each scenario.
module tb_uart_rx;
    localparam int C   = 104;
    localparam int H   = 52;
    localparam int TOL = 2;
    // Cycle of the outcome strobe relative to the first edge that sees the raw fall
    localparam int LAT = 2 + H + 9 * C;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_if bus ();

    uart_rx #(.clk_freq(1000000), .baud_rate(9600)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         kind;   // 0 = good byte, 1 = framing error
        logic [7:0] data;
        int         t;
    } ev_t;

    ev_t        expq[$];
    ev_t        ev;
    logic [7:0] model_data = 8'h00;
    int         n_done = 0;
    int         n_ferr = 0;
    int         done_t[$];
    logic       prev_busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic ok, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison of DUT outputs against the event scoreboard
    always @(negedge clk) begin
        if (rst) begin
            expq.delete();
            model_data = 8'h00;
            prev_busy  = 1'b0;
        end else begin
            chk("exclusive", !(bus.donerx && bus.frame_err), {bus.donerx, bus.frame_err}, 0);
            if (bus.donerx || bus.frame_err) begin
                if (expq.size() == 0) begin
                    chk("spurious_strobe", 1'b0, {bus.donerx, bus.frame_err}, 0);
                end else begin
                    ev = expq.pop_front();
                    chk("event_kind", (bus.donerx ? 0 : 1) == ev.kind, bus.donerx ? 0 : 1, ev.kind);
                    chk("event_time", (cyc >= ev.t - TOL) && (cyc <= ev.t + TOL), cyc, ev.t);
                    if (bus.donerx) begin
                        chk("rx_data_new", bus.rx_data == ev.data, bus.rx_data, ev.data);
                        chk("busy_fall", !bus.busy && prev_busy, {prev_busy, bus.busy}, 2);
                        model_data = ev.data;
                        n_done++;
                        done_t.push_back(cyc);
                    end else begin
                        chk("rx_data_kept", bus.rx_data == model_data, bus.rx_data, model_data);
                        n_ferr++;
                    end
                end
            end else begin
                chk("rx_data_hold", bus.rx_data == model_data, bus.rx_data, model_data);
                if (expq.size() > 0 && cyc > expq[0].t + TOL) begin
                    chk("missing_event", 1'b0, expq[0].kind, expq[0].t);
                    ev = expq.pop_front();
                end
            end
            prev_busy = bus.busy;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic expect_event(input logic [7:0] b, input logic stop);
        ev_t e;
        e.kind = stop ? 0 : 1;
        e.data = b;
        e.t    = cyc + 1 + LAT;
        expq.push_back(e);
    endtask

    // Sends start, 8 data bits LSB first and the stop bit, each p clocks long
    task automatic send(input logic [7:0] b, input logic stop, input int p);
        expect_event(b, stop);
        bus.rx = 1'b0;
        tick(p);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            tick(p);
        end
        bus.rx = stop;
        tick(p);
    endtask

    initial begin
        logic [7:0] f77;
        bus.rx = 1'b1;
        rst    = 1'b1;
        tick(3);
        chk("reset_rx_data", bus.rx_data == 8'h00, bus.rx_data, 8'h00);
        chk("reset_donerx", bus.donerx == 1'b0, bus.donerx, 0);
        chk("reset_frame_err", bus.frame_err == 1'b0, bus.frame_err, 0);
        chk("reset_busy", bus.busy == 1'b0, bus.busy, 0);
        rst = 1'b0;
        tick(20);

        // 1: single good frame
        send(8'hA5, 1'b1, C);
        tick(60);
        chk("t1_rx_data", bus.rx_data == 8'hA5, bus.rx_data, 8'hA5);
        chk("t1_done_cnt", n_done == 1, n_done, 1);
        chk("t1_ferr_cnt", n_ferr == 0, n_ferr, 0);
        chk("t1_busy", bus.busy == 1'b0, bus.busy, 0);

        // 2: short low glitch
        bus.rx = 1'b0;
        tick(20);
        chk("t2_busy_start", bus.busy == 1'b1, bus.busy, 1);
        bus.rx = 1'b1;
        tick(60);
        chk("t2_busy_idle", bus.busy == 1'b0, bus.busy, 0);
        tick(200);
        chk("t2_done_cnt", n_done == 1, n_done, 1);
        chk("t2_ferr_cnt", n_ferr == 0, n_ferr, 0);

        // 3: bad stop bit, line held low, then a good frame
        send(8'h3C, 1'b0, C);
        tick(300);
        chk("t3_ferr_cnt", n_ferr == 1, n_ferr, 1);
        chk("t3_busy_wait", bus.busy == 1'b1, bus.busy, 1);
        chk("t3_rx_data_kept", bus.rx_data == 8'hA5, bus.rx_data, 8'hA5);
        bus.rx = 1'b1;
        tick(20);
        chk("t3_busy_idle", bus.busy == 1'b0, bus.busy, 0);
        send(8'h81, 1'b1, C);
        tick(60);
        chk("t3_rx_data", bus.rx_data == 8'h81, bus.rx_data, 8'h81);
        chk("t3_done_cnt", n_done == 2, n_done, 2);
        chk("t3_ferr_once", n_ferr == 1, n_ferr, 1);

        // 4: back-to-back frames
        send(8'h00, 1'b1, C);
        send(8'hFF, 1'b1, C);
        tick(60);
        chk("t4_done_cnt", n_done == 4, n_done, 4);
        chk("t4_rx_data", bus.rx_data == 8'hFF, bus.rx_data, 8'hFF);
        if (done_t.size() >= 4) begin
            chk("t4_spacing", (done_t[3] - done_t[2] >= 1040 - TOL) && (done_t[3] - done_t[2] <= 1040 + TOL),
                done_t[3] - done_t[2], 1040);
        end else begin
            chk("t4_spacing_present", 1'b0, done_t.size(), 4);
        end

        // 5: reset in the middle of data bit 4 of 0x77
        f77 = 8'h77;
        expect_event(f77, 1'b1);
        bus.rx = 1'b0;
        tick(C);
        for (int i = 0; i < 4; i++) begin
            bus.rx = f77[i];
            tick(C);
        end
        bus.rx = f77[4];
        tick(C / 2);
        rst = 1'b1;
        tick(3);
        chk("t5_reset_rx_data", bus.rx_data == 8'h00, bus.rx_data, 8'h00);
        chk("t5_reset_busy", bus.busy == 1'b0, bus.busy, 0);
        rst    = 1'b0;
        bus.rx = 1'b1;
        tick(12 * C);
        chk("t5_no_strobe", n_done == 4, n_done, 4);
        chk("t5_rx_data_zero", bus.rx_data == 8'h00, bus.rx_data, 8'h00);
        send(8'h5A, 1'b1, C);
        tick(60);
        chk("t5_rx_data", bus.rx_data == 8'h5A, bus.rx_data, 8'h5A);
        chk("t5_done_cnt", n_done == 5, n_done, 5);

        // 6: baud skew, slow and fast sender
        send(8'hC3, 1'b1, 101);
        tick(60);
        chk("t6_fast_rx_data", bus.rx_data == 8'hC3, bus.rx_data, 8'hC3);
        send(8'hC3, 1'b1, 107);
        tick(60);
        chk("t6_done_cnt", n_done == 7, n_done, 7);
        chk("t6_ferr_cnt", n_ferr == 1, n_ferr, 1);
        chk("t6_rx_data", bus.rx_data == 8'hC3, bus.rx_data, 8'hC3);

        tick(5);
        chk("no_pending_events", expq.size() == 0, expq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
